// File: rtl/adc_sample_ctrl.sv
// ADC sequencer: issues channel commands, collects responses with a timeout, reports a result.
// Optional macro ADC_SAMPLE_AVG_EN averages 16 samples instead of returning a single one.
module adc_sample_ctrl #(
  parameter int CHANNEL = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        start,
  output logic        command_valid,
  output logic [4:0]  command_channel,
  output logic        command_startofpacket,
  output logic        command_endofpacket,
  input  logic        command_ready,
  input  logic        response_valid,
  input  logic [4:0]  response_channel,
  input  logic [11:0] response_data,
  input  logic        response_startofpacket,
  input  logic        response_endofpacket,
  output logic [11:0] result_data,
  output logic        result_valid,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [4:0]  CH = 5'(CHANNEL);
  localparam logic [16:0] TO = 17'(TIMEOUT);
`ifdef ADC_SAMPLE_AVG_EN
  localparam int NSAMP = 16;
`else
  localparam int NSAMP = 1;
`endif
  localparam int              CNT_W = $clog2(NSAMP + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSAMP - 1);

  typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;

  state_t           state;
  logic [15:0]      wait_cnt;
  logic [16:0]      wait_nxt;
  logic [CNT_W-1:0] samp_cnt;
  logic             accept;
  logic [11:0]      sample_result;
  logic             unused_pkt;

  assign command_channel       = CH;
  assign command_startofpacket = command_valid;
  assign command_endofpacket   = command_valid;
  assign unused_pkt            = response_startofpacket ^ response_endofpacket;

  assign accept   = (state == WAIT) && response_valid && (response_channel == CH);
  assign wait_nxt = {1'b0, wait_cnt} + 17'd1;

`ifdef ADC_SAMPLE_AVG_EN
  logic [15:0] acc;
  logic [15:0] acc_nxt;
  // 16 x 0xFFF still fits in 16 bits, so the mean is just the top 12 bits.
  assign acc_nxt       = acc + {4'b0, response_data};
  assign sample_result = acc_nxt[15:4];
`else
  assign sample_result = response_data;
`endif

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state         <= IDLE;
      command_valid <= 1'b0;
      result_valid  <= 1'b0;
      result_data   <= '0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
      wait_cnt      <= '0;
      samp_cnt      <= '0;
`ifdef ADC_SAMPLE_AVG_EN
      acc           <= '0;
`endif
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state         <= CMD;
          command_valid <= 1'b1;
          busy          <= 1'b1;
          timeout_err   <= 1'b0;
          samp_cnt      <= '0;
`ifdef ADC_SAMPLE_AVG_EN
          acc           <= '0;
`endif
        end
        CMD: if (command_ready) begin
          state         <= WAIT;
          command_valid <= 1'b0;
          wait_cnt      <= '0;
        end
        WAIT: begin
          // An accepted sample takes priority over a timeout in the same cycle.
          if (accept) begin
`ifdef ADC_SAMPLE_AVG_EN
            acc <= acc_nxt;
`endif
            if (samp_cnt == LAST) begin
              state        <= DONE;
              result_valid <= 1'b1;
              result_data  <= sample_result;
            end else begin
              state         <= CMD;
              command_valid <= 1'b1;
              samp_cnt      <= samp_cnt + CNT_W'(1);
            end
          end else if (wait_nxt == TO) begin
            state       <= IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_nxt[15:0];
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          command_valid <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Randomized scoreboard bench for adc_sample_ctrl with a mean-of-samples reference model.
module tb_adc_sample_ctrl;
  localparam int CH = 1;
  localparam int TO = 10;
`ifdef ADC_SAMPLE_AVG_EN
  localparam int NSAMP = 16;
`else
  localparam int NSAMP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start, command_ready;
  logic        command_valid, command_startofpacket, command_endofpacket;
  logic [4:0]  command_channel, response_channel;
  logic        response_valid, response_startofpacket, response_endofpacket;
  logic [11:0] response_data, result_data;
  logic        result_valid, busy, timeout_err;

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  logic [11:0] exp_q[$];
  logic [11:0] last_exp = '0;

  always #5 clk = ~clk;

  adc_sample_ctrl #(.CHANNEL(CH), .TIMEOUT(TO)) dut (
    .clk_clk(clk), .reset_reset(rst), .start(start),
    .command_valid(command_valid), .command_channel(command_channel),
    .command_startofpacket(command_startofpacket), .command_endofpacket(command_endofpacket),
    .command_ready(command_ready),
    .response_valid(response_valid), .response_channel(response_channel),
    .response_data(response_data),
    .response_startofpacket(response_startofpacket), .response_endofpacket(response_endofpacket),
    .result_data(result_data), .result_valid(result_valid),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: handshake counting, packet framing and result scoreboard.
  always @(negedge clk) begin
    if (command_valid && command_ready) hs_cnt++;
    if (command_valid)
      chk("sop_eop", {30'b0, command_startofpacket, command_endofpacket}, 32'h3);
    if (result_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0h required=none", result_data);
      end else begin
        chk("result_data", result_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_cmd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (command_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wait_cmd actual=no_command required=command_valid");
    end
  endtask

  task automatic other_resp();
    int ch;
    ch = $urandom_range(0, 31);
    if (ch == CH) ch = (CH + 1) % 32;
    response_channel = 5'(ch);
    response_data    = 12'($urandom);
  endtask

  task automatic do_sample(input int rdy_dly, input int resp_dly, input logic [11:0] d,
                           input bit noise, input bit poke, output bit ok);
    wait_cmd(ok);
    if (!ok) return;
    for (int i = 0; i < rdy_dly; i++) begin
      // A matching response before the handshake must be ignored.
      response_valid   = noise;
      response_channel = 5'(CH);
      response_data    = 12'($urandom);
      tick();
      chk("cmd_hold", {26'b0, command_valid, command_channel}, {26'b0, 1'b1, 5'(CH)});
    end
    response_valid = 1'b0;
    command_ready  = 1'b1;
    tick();
    command_ready = 1'b0;
    chk("cmd_drop", {31'b0, command_valid}, 32'h0);
    for (int i = 0; i < resp_dly; i++) begin
      response_valid = noise;
      other_resp();
      start = poke;
      tick();
    end
    start            = 1'b0;
    response_valid   = 1'b1;
    response_channel = 5'(CH);
    response_data    = d;
    tick();
    response_valid = 1'b0;
  endtask

  // fixed<0 -> random data; rdy<0 -> random ready delay; boundary -> response on last WAIT cycle.
  task automatic measure(input int fixed, input int rdy, input bit boundary);
    int sum = 0;
    int hs0;
    bit ok;
    logic [11:0] d;
    hs0 = hs_cnt;
    pulse_start();
    chk("busy_after_start", {31'b0, busy}, 32'h1);
    chk("terr_cleared", {31'b0, timeout_err}, 32'h0);
    for (int s = 0; s < NSAMP; s++) begin
      d = (fixed >= 0) ? 12'(fixed + s) : 12'($urandom);
      sum += int'(d);
      if (s == NSAMP - 1) begin
        last_exp = 12'(sum / NSAMP);
        exp_q.push_back(last_exp);
      end
      do_sample((rdy >= 0) ? rdy : int'($urandom_range(0, 4)),
                boundary ? TO - 1 : int'($urandom_range(0, TO - 2)),
                d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ok);
      if (!ok) return;
    end
    tick();
    chk("idle_after_done", {31'b0, busy}, 32'h0);
    chk("handshakes", 32'(hs_cnt - hs0), 32'(NSAMP));
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    tick();
    chk("result_hold", {20'b0, result_data}, {20'b0, last_exp});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_valid"}, {29'b0, command_valid, command_startofpacket, command_endofpacket}, 32'h0);
    chk({tag, "_channel"}, {27'b0, command_channel}, 32'(CH));
    chk({tag, "_flags"}, {29'b0, result_valid, busy, timeout_err}, 32'h0);
    chk({tag, "_result_data"}, {20'b0, result_data}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=stuck required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit ok;
    rst = 1'b0; start = 1'b0; command_ready = 1'b0;
    response_valid = 1'b0; response_channel = '0; response_data = '0;
    response_startofpacket = 1'b0; response_endofpacket = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    measure((NSAMP == 1) ? 12'hABC : 12'h100, 0, 1'b0);
    measure(-1, 20, 1'b0);
    measure(-1, -1, 1'b1);
    measure(4096 - NSAMP, -1, 1'b0);
    measure(0, -1, 1'b0);
    for (int k = 0; k < 8; k++) measure(-1, -1, 1'(k % 3 == 0));

    // Timeout: no response after the handshake.
    pulse_start();
    wait_cmd(ok);
    command_ready = 1'b1;
    tick();
    command_ready = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'(TO));
    chk("timeout_flags", {30'b0, timeout_err, busy}, 32'h2);
    repeat (3) tick();
    chk("timeout_sticky", {31'b0, timeout_err}, 32'h1);
    measure(-1, -1, 1'b0);

    // Reset mid-WAIT.
    pulse_start();
    wait_cmd(ok);
    command_ready = 1'b1;
    tick();
    command_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_wait");
    tick();
    rst = 1'b0;
    tick();
    measure(-1, -1, 1'b0);

    // Reset mid-CMD.
    pulse_start();
    chk("cmd_before_rst", {31'b0, command_valid}, 32'h1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_cmd");
    tick();
    rst = 1'b0;
    tick();
    measure(-1, -1, 1'b0);

    chk("final_queue", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
